clut_seq: RTL
=============

CLUT_SEQ -- requirements
Module: clut_seq

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, write-queue entries (power of two, 2..16).
REQ-002 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port reg_wr  in  1  custom-register write strobe, one cycle per write.
REQ-005 SHALL have port reg_addr  in  8  register word address (byte address bits 8:1).
REQ-006 SHALL have port reg_data  in  16  register write data.
REQ-007 SHALL have port clr_req  in  1  request palette clear, one-cycle pulse.
REQ-008 SHALL have port pix_en  in  1  pixel lookup request.
REQ-009 SHALL have port pix_idx  in  5  pixel colour index.
REQ-010 SHALL have port cpu_wr  out  1  table write enable.
REQ-011 SHALL have port cpu_idx  out  5  table write index.
REQ-012 SHALL have port cpu_rgb  out  12  table write data.
REQ-013 SHALL have port clut_rd  out  1  table read enable.
REQ-014 SHALL have port clut_idx  out  5  table read index.
REQ-015 SHALL have port clut_rgb  in  12  table read data, valid 2 edges after clut_rd.
REQ-016 SHALL have port pix_rgb  out  12  gated pixel colour.
REQ-017 SHALL have port pix_vld  out  1  pix_rgb valid.
REQ-018 SHALL have port busy  out  1  high while state is INIT.
REQ-019 SHALL have port ovf  out  1  sticky write-queue overflow flag.
REQ-020 SHALL have port fifo_lvl  out  5  current queue occupancy.

Function
REQ-021 SHALL decode a colour write when reg_wr=1 and reg_addr[7:5]=3'b110 (bytes $180-$1BE); idx=reg_addr[4:0], rgb=reg_data[11:0], reg_data[15:12] ignored; other addresses ignored.
REQ-022 SHALL push each decoded colour write {idx,rgb} into a FIFO_DEPTH-entry FIFO at the sampling edge if not full.
REQ-023 SHALL, when full and no pop at the same edge, drop the write, leave the FIFO unchanged and set ovf=1; ovf clears only on reset.
REQ-024 SHALL allow push and pop at the same edge, including when full (no drop, level unchanged).
REQ-025 SHALL implement states INIT and RUN; reset enters INIT with clear counter=0.
REQ-026 SHALL, in INIT, register cpu_wr=1, cpu_idx=counter, cpu_rgb=12'h000 each edge, counter 0..31 one per cycle, then enter RUN the edge after issuing index 31 (32 consecutive write cycles); the FIFO is not popped.
REQ-027 SHALL, in RUN with FIFO non-empty, pop the head at each edge and register cpu_wr=1, cpu_idx/cpu_rgb=head; otherwise register cpu_wr=0 (cpu_idx/cpu_rgb hold).
REQ-028 SHALL yield latency on an empty FIFO in RUN: write sampled at edge k -> cpu_wr high in the cycle following edge k+1.
REQ-029 SHALL, on clr_req=1 in RUN, enter INIT at the next edge with counter=0 and flush the FIFO (pending and same-edge writes discarded, ovf unaffected); clr_req in INIT SHALL be ignored.
REQ-030 SHALL apply queued writes in FIFO order; a write arriving during INIT SHALL be queued and applied after INIT ends.
REQ-031 SHALL drive clut_rd=pix_en and clut_idx=pix_idx combinationally, in both states.
REQ-032 SHALL delay pix_en through two registers; pix_vld = second stage; pix_rgb = clut_rgb when pix_vld=1, else 12'h000.
REQ-033 SHALL drive busy=1 exactly in INIT; fifo_lvl = 0..FIFO_DEPTH.

Reset
REQ-034 SHALL, while rst=1, asynchronously force cpu_wr=0, cpu_idx=0, cpu_rgb=0, pix_vld=0, ovf=0, fifo_lvl=0, busy=1, state INIT, counter 0, both pix_en delay stages 0.
REQ-035 SHALL, on rst deassertion, begin INIT clearing at the first clock edge; reset mid-INIT or mid-drain restarts clearing from index 0 and discards queued writes.

Verification
REQ-036 SHALL cover post-reset clear: release rst -> cpu_wr high 32 cycles, cpu_idx 0..31, cpu_rgb 0, busy falls after the 32nd cycle.
REQ-037 SHALL cover basic write: in RUN, reg_wr, reg_addr=8'hC5, reg_data=16'hF123 -> one cycle later cpu_wr=1, cpu_idx=5, cpu_rgb=12'h123; reg_addr=8'hA0 -> no write.
REQ-038 SHALL cover overflow: 6 colour writes on consecutive cycles during INIT (depth 4) -> first 4 applied in order after INIT, last 2 dropped, ovf=1, fifo_lvl peaks at 4.
REQ-039 SHALL cover clear flush: 3 queued writes during INIT; after RUN, clr_req coincident with a new write -> busy=1, 32 zero writes, no queued or coincident write applied.
REQ-040 SHALL cover pixel pipe: pix_en=1, pix_idx=7 at edge k, clut_rgb=12'hABC two edges later -> pix_vld=1, pix_rgb=12'hABC; pix_en=0 -> pix_rgb=12'h000.
REQ-041 SHALL cover async reset mid-drain: assert rst with fifo_lvl=2 -> outputs immediately at REQ-034 values, clear restarts from index 0.

Source files
------------

// File: rtl/clut_seq_if.sv
// Custom-register write bus feeding the colour lookup table sequencer.
interface clut_seq_if;
    logic        reg_wr;
    logic [7:0]  reg_addr;
    logic [15:0] reg_data;

    modport master (output reg_wr, reg_addr, reg_data);
    modport slave  (input  reg_wr, reg_addr, reg_data);
endinterface

// File: rtl/clut_seq.sv
// Colour lookup table sequencer: power-up/clear fill, queued register writes
// into the table, and a two-stage pixel lookup pipe.
module clut_seq #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    clut_seq_if.slave        reg_bus,
    input  logic             clr_req,
    input  logic             pix_en,
    input  logic [4:0]       pix_idx,
    output logic             cpu_wr,
    output logic [4:0]       cpu_idx,
    output logic [11:0]      cpu_rgb,
    output logic             clut_rd,
    output logic [4:0]       clut_idx,
    input  logic [11:0]      clut_rgb,
    output logic [11:0]      pix_rgb,
    output logic             pix_vld,
    output logic             busy,
    output logic             ovf,
    output logic [4:0]       fifo_lvl
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t        state_q, state_d;
    logic [4:0]    clr_cnt_q, clr_cnt_d;
    logic [16:0]   mem_q [FIFO_DEPTH];
    logic [16:0]   mem_d [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [4:0]    lvl_q, lvl_d;
    logic          ovf_q, ovf_d;
    logic          cpu_wr_q, cpu_wr_d;
    logic [4:0]    cpu_idx_q, cpu_idx_d;
    logic [11:0]   cpu_rgb_q, cpu_rgb_d;
    logic          pix_d1_q, pix_d1_d;
    logic          pix_vld_q, pix_vld_d;

    logic wr_hit, full, empty, flush, pop, push;

    always_comb begin
        wr_hit = reg_bus.reg_wr && (reg_bus.reg_addr[7:5] == 3'b110);
        full   = (lvl_q == 5'(FIFO_DEPTH));
        empty  = (lvl_q == '0);
        // A clear in RUN wins over draining: nothing queued or arriving is applied.
        flush  = (state_q == ST_RUN) && clr_req;
        pop    = (state_q == ST_RUN) && !clr_req && !empty;
        push   = wr_hit && !flush && (!full || pop);

        mem_d     = mem_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        lvl_d     = lvl_q;
        ovf_d     = ovf_q;
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        cpu_wr_d  = 1'b0;
        cpu_idx_d = cpu_idx_q;
        cpu_rgb_d = cpu_rgb_q;
        pix_d1_d  = pix_en;
        pix_vld_d = pix_d1_q;

        if (push) begin
            mem_d[wr_ptr_q] = {reg_bus.reg_addr[4:0], reg_bus.reg_data[11:0]};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   lvl_d = lvl_q + 5'd1;
            2'b01:   lvl_d = lvl_q - 5'd1;
            default: lvl_d = lvl_q;
        endcase
        if (wr_hit && full && !pop && !flush) begin
            ovf_d = 1'b1;
        end

        case (state_q)
            ST_INIT: begin
                cpu_wr_d  = 1'b1;
                cpu_idx_d = clr_cnt_q;
                cpu_rgb_d = '0;
                clr_cnt_d = clr_cnt_q + 5'd1;
                if (clr_cnt_q == 5'd31) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                if (flush) begin
                    state_d   = ST_INIT;
                    clr_cnt_d = '0;
                    rd_ptr_d  = '0;
                    wr_ptr_d  = '0;
                    lvl_d     = '0;
                end else if (pop) begin
                    cpu_wr_d  = 1'b1;
                    cpu_idx_d = mem_q[rd_ptr_q][16:12];
                    cpu_rgb_d = mem_q[rd_ptr_q][11:0];
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_INIT;
            clr_cnt_q <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            lvl_q     <= '0;
            ovf_q     <= 1'b0;
            cpu_wr_q  <= 1'b0;
            cpu_idx_q <= '0;
            cpu_rgb_q <= '0;
            pix_d1_q  <= 1'b0;
            pix_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            lvl_q     <= lvl_d;
            ovf_q     <= ovf_d;
            cpu_wr_q  <= cpu_wr_d;
            cpu_idx_q <= cpu_idx_d;
            cpu_rgb_q <= cpu_rgb_d;
            pix_d1_q  <= pix_d1_d;
            pix_vld_q <= pix_vld_d;
        end
    end

    // Queue storage needs no reset; occupancy and pointers define validity.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign cpu_wr   = cpu_wr_q;
    assign cpu_idx  = cpu_idx_q;
    assign cpu_rgb  = cpu_rgb_q;
    assign clut_rd  = pix_en;
    assign clut_idx = pix_idx;
    assign pix_vld  = pix_vld_q;
    assign pix_rgb  = pix_vld_q ? clut_rgb : 12'h000;
    assign busy     = (state_q == ST_INIT);
    assign ovf      = ovf_q;
    assign fifo_lvl = lvl_q;

endmodule
